// File: rtl/riscv_memory_ahb4.sv
// ============================================================================
// riscv_memory_ahb4
// ----------------------------------------------------------------------------
// AHB-Lite (AHB4) single-port SRAM responder. It can terminate either the
// instruction or the data master port of the processing unit. It serves as the
// TCM/boot memory model in PU subsystems and as the reference slave in PU
// testbenches.
//
// Features:
//   - zero-wait or programmable-wait (WAIT_STATES) OKAY data phases
//   - byte / halfword / word writes with per-lane byte enables
//   - two-cycle ERROR response for bad size or misaligned transfers
//   - same-edge read-after-write forwarding, so back-to-back write->read of
//     the same word returns the merged (post-write) data with zero waits
//
// Optional build macro:
//   RISCV_MEMORY_AHB4_RANGE_CHECK_EN
//     defined   : an address outside [BASE_ADDR, BASE_ADDR+MEM_SIZE-1] gets
//                 the ERROR response and never writes memory
//     undefined : no range check; the word index is taken from the low bits
//                 of (HADDR-BASE_ADDR), so accesses wrap modulo MEM_SIZE
//
// Ports:
//   HCLK       in   1     bus clock, all state updates on the rising edge
//   HRESETn    in   1     asynchronous active-low reset
//   HSEL       in   1     slave select
//   HADDR      in   PLEN  byte address (address phase)
//   HWDATA     in   XLEN  write data (data phase)
//   HRDATA     out  XLEN  read data (data phase), full aligned word
//   HWRITE     in   1     1 = write, 0 = read
//   HSIZE      in   3     0 = byte, 1 = halfword, 2 = word
//   HBURST     in   3     burst type, ignored
//   HPROT      in   4     protection, ignored
//   HTRANS     in   2     0 = IDLE, 1 = BUSY, 2 = NONSEQ, 3 = SEQ
//   HMASTLOCK  in   1     ignored
//   HREADY     in   1     bus-level ready (previous transfer complete)
//   HREADYOUT  out  1     slave ready
//   HRESP      out  1     0 = OKAY, 1 = ERROR
// ============================================================================
module riscv_memory_ahb4 #(
  parameter int              XLEN        = 32,
  parameter int              PLEN        = 32,
  parameter int              MEM_SIZE    = 4096,
  parameter logic [PLEN-1:0] BASE_ADDR   = 'h8000_0000,
  parameter int              WAIT_STATES = 0
) (
  input  logic            HCLK,
  input  logic            HRESETn,
  input  logic            HSEL,
  input  logic [PLEN-1:0] HADDR,
  input  logic [XLEN-1:0] HWDATA,
  output logic [XLEN-1:0] HRDATA,
  input  logic            HWRITE,
  input  logic [2:0]      HSIZE,
  input  logic [2:0]      HBURST,
  input  logic [3:0]      HPROT,
  input  logic [1:0]      HTRANS,
  input  logic            HMASTLOCK,
  input  logic            HREADY,
  output logic            HREADYOUT,
  output logic            HRESP
);

  localparam int         WORDS     = MEM_SIZE / 4;
  localparam int         IDX_W     = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } state_t;

  state_t state_q;
  state_t state_d;

  // Address-phase information captured on the accepting edge
  logic [IDX_W-1:0] idx_q;
  logic [1:0]       lo_q;
  logic [2:0]       size_q;
  logic             write_q;
  logic [3:0]       cnt_q;
  logic [XLEN-1:0]  rdata_q;

  logic [XLEN-1:0]  mem [WORDS];

  logic [PLEN-1:0]  offset;
  logic [IDX_W-1:0] addr_idx;
  logic             size_err;
  logic             align_err;
  logic             range_err;
  logic             xfer_err;
  logic             accept;
  logic             accept_state;
  logic             accept_en;
  logic             commit;
  logic [3:0]       commit_be;
  logic [XLEN-1:0]  commit_mask;
  logic [XLEN-1:0]  merged_word;
  logic [XLEN-1:0]  fwd_word;

  // Bus inputs that carry no meaning for a plain SRAM, plus the upper offset
  // bits that only the range check looks at, are folded into one sink net.
  logic unused_inputs;
  assign unused_inputs = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0], offset};

  // Lane enables for a transfer of the given size at the given low address
  // bits. Misaligned cases never reach a commit, so they need no special care.
  function automatic logic [3:0] lane_enables(input logic [1:0] lo,
                                               input logic [2:0] size);
    logic [3:0] be;
    be = 4'b0000;
    case (size)
      3'd0:    be = 4'b0001 << lo;
      3'd1:    be = lo[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Word index relative to BASE_ADDR. Masking with WORDS-1 makes the
  // out-of-range case wrap modulo MEM_SIZE when no range check is built in.
  assign offset   = HADDR - BASE_ADDR;
  assign addr_idx = IDX_W'(offset >> 2) & IDX_W'(WORDS - 1);

  // Transfer legality, evaluated on the address phase
  assign size_err  = (HSIZE > 3'd2);
  assign align_err = ((HSIZE == 3'd1) && HADDR[0]) ||
                     ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00));

`ifdef RISCV_MEMORY_AHB4_RANGE_CHECK_EN
  // Relies on unsigned wrap: an address below BASE_ADDR yields a huge offset.
  assign range_err = (offset >= PLEN'(MEM_SIZE));
`else
  assign range_err = 1'b0;
`endif

  assign xfer_err = size_err | align_err | range_err;

  // A new address phase is only taken in states that drive HREADYOUT high,
  // i.e. where the slave itself is completing or idle.
  assign accept       = HSEL & HREADY & HTRANS[1];
  assign accept_state = (state_q == ST_IDLE) || (state_q == ST_DATA) ||
                        (state_q == ST_ERR2);
  assign accept_en    = accept & accept_state;

  // The write in the current data phase lands on the edge that ends DATA.
  // The merged word is also what a read accepted on that same edge must see.
  assign commit    = (state_q == ST_DATA) && write_q;
  assign commit_be = lane_enables(lo_q, size_q);

  always_comb begin
    commit_mask = '0;
    for (int b = 0; b < 4; b++) begin
      commit_mask[8*b +: 8] = {8{commit_be[b]}};
    end
  end

  assign merged_word = (mem[idx_q] & ~commit_mask) | (HWDATA & commit_mask);
  assign fwd_word    = (commit && (idx_q == addr_idx)) ? merged_word
                                                       : mem[addr_idx];

  // Next-state logic. IDLE, DATA and ERR2 share the same accept rules because
  // all three present HREADYOUT=1 and can start the next transfer.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_DATA, ST_ERR2: begin
        state_d = ST_IDLE;
        if (accept) begin
          if (xfer_err) begin
            state_d = ST_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_d = ST_WAIT;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q <= 4'd1) begin
          state_d = ST_DATA;
        end
      end
      ST_ERR1: begin
        state_d = ST_ERR2;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Response outputs depend on the state register only, which keeps them free
  // of any path from HREADY (often tied straight back from HREADYOUT).
  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    unique case (state_q)
      ST_WAIT: HREADYOUT = 1'b0;
      ST_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
      end
      ST_ERR2: HRESP = 1'b1;
      default: begin
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
      end
    endcase
  end

  // State register
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Address-phase capture, wait counter and read-data register. The read
  // word is loaded on the accepting edge when there are no waits, otherwise
  // on the last wait edge; by then any earlier write has already landed.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      idx_q   <= '0;
      lo_q    <= 2'b00;
      size_q  <= 3'b000;
      write_q <= 1'b0;
      cnt_q   <= 4'd0;
      rdata_q <= '0;
    end else if (accept_en) begin
      idx_q   <= addr_idx;
      lo_q    <= HADDR[1:0];
      size_q  <= HSIZE;
      write_q <= HWRITE;
      cnt_q   <= WAIT_INIT;
      if (!HWRITE && !xfer_err && (WAIT_STATES == 0)) begin
        rdata_q <= fwd_word;
      end
    end else if (state_q == ST_WAIT) begin
      cnt_q <= cnt_q - 4'd1;
      if ((cnt_q <= 4'd1) && !write_q) begin
        rdata_q <= mem[idx_q];
      end
    end
  end

  // Storage array; intentionally not reset. A reset during a write's wait
  // phase forces IDLE, so that write never reaches DATA and never commits.
  always_ff @(posedge HCLK) begin
    if (commit) begin
      mem[idx_q] <= merged_word;
    end
  end

  assign HRDATA = rdata_q;

endmodule

// File: tb/tb_riscv_memory_ahb4.sv
// ============================================================================
// tb_riscv_memory_ahb4
// ----------------------------------------------------------------------------
// Self-checking bench for riscv_memory_ahb4. Two instances share one bus:
// a zero-wait one and a three-wait one, picked by use_slow. A small pipelined
// AHB master issues queued transfers; each issued transfer pushes its
// expected response (from a byte-lane shadow memory) onto a scoreboard
// queue, which is popped when the data phase completes.
// ============================================================================
`timescale 1ns/1ps

module tb_riscv_memory_ahb4;

  localparam int          MEM_SIZE = 4096;
  localparam int          WORDS    = MEM_SIZE / 4;
  localparam logic [31:0] BASE     = 32'h8000_0000;
  localparam int          WS_SLOW  = 3;

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
  } stim_t;

  typedef struct {
    logic        is_read;
    logic        err;
    logic [31:0] data;
    int          waits;
  } exp_t;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic [31:0] haddr;
  logic [31:0] hwdata;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [1:0]  htrans;
  logic        sel_fast;
  logic        sel_slow;
  logic        use_slow;

  logic [31:0] rdata_fast;
  logic [31:0] rdata_slow;
  logic        rdy_fast;
  logic        rdy_slow;
  logic        resp_fast;
  logic        resp_slow;

  logic        cur_rdy;
  logic        cur_resp;
  logic [31:0] cur_rdata;

  stim_t       stim_q[$];
  string       stim_tag_q[$];
  exp_t        exp_q[$];
  string       exp_tag_q[$];
  logic [31:0] model [2][WORDS];

  int check_count = 0;
  int error_count = 0;

  always #5 hclk = ~hclk;

  assign cur_rdy   = use_slow ? rdy_slow   : rdy_fast;
  assign cur_resp  = use_slow ? resp_slow  : resp_fast;
  assign cur_rdata = use_slow ? rdata_slow : rdata_fast;

  riscv_memory_ahb4 #(
    .XLEN(32), .PLEN(32), .MEM_SIZE(MEM_SIZE), .BASE_ADDR(BASE), .WAIT_STATES(0)
  ) u_dut_fast (
    .HCLK(hclk), .HRESETn(hresetn), .HSEL(sel_fast), .HADDR(haddr),
    .HWDATA(hwdata), .HRDATA(rdata_fast), .HWRITE(hwrite), .HSIZE(hsize),
    .HBURST(3'b001), .HPROT(4'b0011), .HTRANS(htrans), .HMASTLOCK(1'b0),
    .HREADY(rdy_fast), .HREADYOUT(rdy_fast), .HRESP(resp_fast)
  );

  riscv_memory_ahb4 #(
    .XLEN(32), .PLEN(32), .MEM_SIZE(MEM_SIZE), .BASE_ADDR(BASE), .WAIT_STATES(WS_SLOW)
  ) u_dut_slow (
    .HCLK(hclk), .HRESETn(hresetn), .HSEL(sel_slow), .HADDR(haddr),
    .HWDATA(hwdata), .HRDATA(rdata_slow), .HWRITE(hwrite), .HSIZE(hsize),
    .HBURST(3'b001), .HPROT(4'b0011), .HTRANS(htrans), .HMASTLOCK(1'b0),
    .HREADY(rdy_slow), .HREADYOUT(rdy_slow), .HRESP(resp_slow)
  );

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic queueOp(input string tag, input logic write, input logic [31:0] addr,
                         input logic [2:0] size, input logic [31:0] wdata);
    stim_t s;
    s.write = write;
    s.addr  = addr;
    s.size  = size;
    s.wdata = wdata;
    stim_q.push_back(s);
    stim_tag_q.push_back(tag);
  endtask

  task automatic idleBus();
    htrans   = 2'b00;
    sel_fast = 1'b0;
    sel_slow = 1'b0;
  endtask

  // Work out the response of an issued transfer from the shadow memory,
  // apply its write to the shadow, and push the expectation.
  task automatic predictPush(input stim_t s, input string tag);
    exp_t        e;
    int          d;
    int          idx;
    logic [31:0] w;
    logic        lane_on;
    d         = use_slow ? 1 : 0;
    e.is_read = !s.write;
    e.err     = (s.size > 3'd2) ||
                ((s.size == 3'd1) && (s.addr[0] == 1'b1)) ||
                ((s.size == 3'd2) && (s.addr[1:0] != 2'b00));
`ifdef RISCV_MEMORY_AHB4_RANGE_CHECK_EN
    if ((s.addr < BASE) || (s.addr >= BASE + 32'(MEM_SIZE))) e.err = 1'b1;
`endif
    e.waits = e.err ? 1 : (use_slow ? WS_SLOW : 0);
    idx     = int'((s.addr - BASE) >> 2) % WORDS;
    w       = model[d][idx];
    e.data  = w;
    if (s.write && !e.err) begin
      for (int b = 0; b < 4; b++) begin
        case (s.size)
          3'd0:    lane_on = (b == int'(s.addr[1:0]));
          3'd1:    lane_on = ((b / 2) == int'(s.addr[1]));
          default: lane_on = 1'b1;
        endcase
        if (lane_on) w[8*b +: 8] = s.wdata[8*b +: 8];
      end
      model[d][idx] = w;
    end
    exp_q.push_back(e);
    exp_tag_q.push_back(tag);
  endtask

  // Pipelined master: runs the stimulus queue dry. Outputs are sampled on the
  // falling edge; address/data phases advance on rising edges where ready.
  task automatic applyStimulus();
    stim_t       cur;
    string       ctag;
    exp_t        e;
    string       etag;
    bit          addr_valid;
    bit          dp_valid;
    bit          aborted;
    int          waits;
    int          guard;
    logic        r_rdy;
    logic        r_resp;
    logic [31:0] r_data;
    addr_valid = 0;
    dp_valid   = 0;
    aborted    = 0;
    waits      = 0;
    guard      = 0;
    while ((stim_q.size() > 0 || addr_valid || dp_valid) && guard < 2000 && !aborted) begin
      guard++;
      @(negedge hclk);
      r_rdy  = cur_rdy;
      r_resp = cur_resp;
      r_data = cur_rdata;
      if (dp_valid) begin
        if (!r_rdy) begin
          waits++;
          checkOutput({exp_tag_q[0], " resp during wait"}, 32'(r_resp), 32'(exp_q[0].err));
          if (waits > 40) begin
            checkOutput({exp_tag_q[0], " wait timeout"}, 32'(waits), 32'(exp_q[0].waits));
            aborted = 1;
          end
        end else begin
          e    = exp_q.pop_front();
          etag = exp_tag_q.pop_front();
          checkOutput({etag, " waits"}, 32'(waits), 32'(e.waits));
          checkOutput({etag, " resp"}, 32'(r_resp), 32'(e.err));
          if (e.is_read && !e.err) checkOutput({etag, " rdata"}, r_data, e.data);
        end
      end
      if (!aborted) begin
        @(posedge hclk);
        if (r_rdy) begin
          dp_valid = addr_valid;
          waits    = 0;
          #1;
          if (dp_valid) hwdata = cur.wdata;
          if (stim_q.size() > 0) begin
            cur  = stim_q.pop_front();
            ctag = stim_tag_q.pop_front();
            haddr    = cur.addr;
            hwrite   = cur.write;
            hsize    = cur.size;
            htrans   = {1'b1, 1'($urandom_range(0, 1))};
            sel_fast = !use_slow;
            sel_slow = use_slow;
            predictPush(cur, ctag);
            addr_valid = 1;
          end else begin
            idleBus();
            addr_valid = 0;
          end
        end
      end
    end
    if (guard >= 2000) checkOutput("master loop bound", 32'(guard), 32'd0);
    if (aborted || guard >= 2000) begin
      idleBus();
      stim_q.delete();
      stim_tag_q.delete();
      exp_q.delete();
      exp_tag_q.delete();
      @(posedge hclk);
      #1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors so far %0d", error_count);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] addr;
    logic [2:0]  sz;
    logic [1:0]  lo;
    int unsigned w;
    bit          rw;

    hresetn  = 1'b0;
    haddr    = 32'h0;
    hwdata   = 32'h0;
    hwrite   = 1'b0;
    hsize    = 3'd0;
    use_slow = 1'b0;
    idleBus();

    // Reset state of both instances
    repeat (3) @(posedge hclk);
    @(negedge hclk);
    checkOutput("reset fast hreadyout", 32'(rdy_fast), 32'd1);
    checkOutput("reset fast hresp",     32'(resp_fast), 32'd0);
    checkOutput("reset fast hrdata",    rdata_fast, 32'h0);
    checkOutput("reset slow hreadyout", 32'(rdy_slow), 32'd1);
    checkOutput("reset slow hresp",     32'(resp_slow), 32'd0);
    checkOutput("reset slow hrdata",    rdata_slow, 32'h0);
    hresetn = 1'b1;

    // Zero-wait: write then immediate read of the same word (forwarding)
    $display("[TB] zero-wait write/read forwarding");
    queueOp("fwd wr",   1'b1, BASE + 32'h10, 3'd2, 32'hDEAD_BEEF);
    queueOp("fwd rd",   1'b0, BASE + 32'h10, 3'd2, 32'h0);
    // Sub-word writes merging into an existing word
    queueOp("base wr",  1'b1, BASE + 32'h10, 3'd2, 32'h1122_3344);
    queueOp("byte wr",  1'b1, BASE + 32'h13, 3'd0, 32'hAA00_0000);
    queueOp("byte rd",  1'b0, BASE + 32'h10, 3'd2, 32'h0);
    queueOp("half wr",  1'b1, BASE + 32'h10, 3'd1, 32'h0000_5566);
    queueOp("half rd",  1'b0, BASE + 32'h10, 3'd2, 32'h0);
    queueOp("hhi wr",   1'b1, BASE + 32'h12, 3'd1, 32'h7788_0000);
    queueOp("hhi rd",   1'b0, BASE + 32'h10, 3'd0, 32'h0);
    // Error transfers leave memory untouched
    queueOp("mis half", 1'b1, BASE + 32'h11, 3'd1, 32'hFFFF_FFFF);
    queueOp("mis word", 1'b1, BASE + 32'h12, 3'd2, 32'hFFFF_FFFF);
    queueOp("bad size", 1'b0, BASE + 32'h10, 3'd3, 32'h0);
    queueOp("mis h01",  1'b1, BASE + 32'h01, 3'd1, 32'hFFFF_FFFF);
    queueOp("post err", 1'b0, BASE + 32'h10, 3'd2, 32'h0);
    // Wrap-around (or range error when the check is built in)
    queueOp("loc0 wr",  1'b1, BASE + 32'h0,    3'd2, 32'hCAFE_0001);
    queueOp("loc1 wr",  1'b1, BASE + 32'h4,    3'd2, 32'h1234_5678);
    queueOp("alias rd", 1'b0, BASE + 32'h1000, 3'd2, 32'h0);
    queueOp("alias wr", 1'b1, BASE + 32'h1004, 3'd2, 32'h8765_4321);
    queueOp("loc1 rd",  1'b0, BASE + 32'h4,    3'd2, 32'h0);
    applyStimulus();

    // Randomised mixed-size traffic over a small window
    $display("[TB] random traffic");
    for (int i = 0; i < 8; i++) begin
      queueOp("rnd init", 1'b1, BASE + 32'h20 + 32'(i * 4), 3'd2, $urandom());
    end
    for (int i = 0; i < 24; i++) begin
      w  = $urandom_range(0, 7);
      sz = 3'($urandom_range(0, 2));
      rw = 1'($urandom_range(0, 1));
      if (sz == 3'd0)      lo = 2'($urandom_range(0, 3));
      else if (sz == 3'd1) lo = {1'($urandom_range(0, 1)), 1'b0};
      else                 lo = 2'b00;
      addr = BASE + 32'h20 + 32'(w * 4) + 32'(lo);
      queueOp(rw ? "rnd wr" : "rnd rd", rw, addr, sz, $urandom());
    end
    applyStimulus();

    // BUSY with HSEL high is not a transfer: OKAY, ready, nothing written
    $display("[TB] busy transfer ignored");
    haddr    = BASE + 32'h10;
    hwrite   = 1'b1;
    hsize    = 3'd2;
    htrans   = 2'b01;
    sel_fast = 1'b1;
    hwdata   = 32'h0;
    for (int i = 0; i < 2; i++) begin
      @(negedge hclk);
      checkOutput("busy hreadyout", 32'(rdy_fast), 32'd1);
      checkOutput("busy hresp",     32'(resp_fast), 32'd0);
      @(posedge hclk);
      #1;
    end
    idleBus();
    queueOp("after busy", 1'b0, BASE + 32'h10, 3'd2, 32'h0);
    applyStimulus();

    // Wait-state instance: three low cycles per OKAY data phase
    $display("[TB] wait-state transfers");
    use_slow = 1'b1;
    queueOp("ws wr",    1'b1, BASE + 32'h40, 3'd2, 32'h0BAD_F00D);
    queueOp("ws rd",    1'b0, BASE + 32'h40, 3'd2, 32'h0);
    queueOp("ws byte",  1'b1, BASE + 32'h41, 3'd0, 32'h0000_5A00);
    queueOp("ws rd2",   1'b0, BASE + 32'h40, 3'd2, 32'h0);
    queueOp("ws err",   1'b1, BASE + 32'h41, 3'd1, 32'hFFFF_FFFF);
    queueOp("ws rd3",   1'b0, BASE + 32'h40, 3'd2, 32'h0);
    applyStimulus();

    // Reset in the wait phase of a write aborts it without committing
    $display("[TB] reset during wait");
    haddr    = BASE + 32'h40;
    hwrite   = 1'b1;
    hsize    = 3'd2;
    htrans   = 2'b10;
    sel_slow = 1'b1;
    @(posedge hclk);
    #1;
    idleBus();
    hwdata = 32'hFFFF_FFFF;
    @(negedge hclk);
    checkOutput("pre-reset hreadyout", 32'(rdy_slow), 32'd0);
    hresetn = 1'b0;
    #1;
    checkOutput("mid-reset hreadyout", 32'(rdy_slow), 32'd1);
    checkOutput("mid-reset hresp",     32'(resp_slow), 32'd0);
    checkOutput("mid-reset hrdata",    rdata_slow, 32'h0);
    repeat (2) @(negedge hclk);
    hresetn = 1'b1;
    queueOp("post-reset rd", 1'b0, BASE + 32'h40, 3'd2, 32'h0);
    applyStimulus();

    repeat (2) @(posedge hclk);
    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule

// File: doc/riscv_memory_ahb4.md
Name: riscv_memory_ahb4

Overview:
- AHB-Lite (AHB4) responder: a single-port SRAM slave that terminates either the ins_* or dat_* master port of the processing unit.
- Supports zero-wait or programmable-wait transfers, byte/halfword/word writes, and the two-cycle ERROR response.
- Used as the TCM/boot-memory model in PU subsystems and as the reference slave in PU testbenches.

Parameters:
- XLEN, 32, data bus width; only 32 supported.
- PLEN, 32, address bus width.
- MEM_SIZE, 4096, memory size in bytes; power of two, at least 4.
- BASE_ADDR, 'h8000_0000, byte address of memory location 0.
- WAIT_STATES, 0, wait cycles inserted in every OKAY data phase; range 0..15.

Ports:
- HCLK  in  1  bus clock; all state updates on rising edge.
- HRESETn  in  1  asynchronous active-low reset.
- HSEL  in  1  slave select.
- HADDR  in  PLEN  byte address (address phase).
- HWDATA  in  XLEN  write data (data phase).
- HRDATA  out  XLEN  read data (data phase).
- HWRITE  in  1  1=write, 0=read.
- HSIZE  in  3  transfer size: 0=byte, 1=half, 2=word.
- HBURST  in  3  burst type; informational only, ignored.
- HPROT  in  4  protection; ignored.
- HTRANS  in  2  0=IDLE, 1=BUSY, 2=NONSEQ, 3=SEQ.
- HMASTLOCK  in  1  ignored.
- HREADY  in  1  bus-level ready; previous transfer complete.
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  0=OKAY, 1=ERROR.

Behaviour:
- Reset (asynchronous, HRESETn=0): state IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, wait counter=0, all latched address-phase registers=0. Memory array is not reset.
- Reset asserted mid-transfer aborts the transfer; a pending write is not committed.
- Accept: address phase is accepted on an edge where HSEL & HREADY & HTRANS[1]=1.
  - Latch word index, HADDR[1:0], HSIZE, HWRITE; load wait counter with WAIT_STATES.
- IDLE or BUSY with HSEL=1, and any cycle with HSEL=0: no transfer; next data phase is OKAY with zero wait.
- Error check at accept: any of the following is an error transfer.
  - HSIZE>2.
  - Misalignment: size 1 with HADDR[0]=1, or size 2 with HADDR[1:0]≠0.
- States:
  - IDLE: HREADYOUT=1, HRESP=0. On accept: error -> ERR1; WAIT_STATES>0 -> WAIT; else DATA.
  - WAIT: HREADYOUT=0, HRESP=0; counter decrements each cycle. Counter reaches 1 -> DATA.
  - DATA: HREADYOUT=1, HRESP=0; transfer completes this cycle.
    - New accept in the same cycle follows the IDLE rules.
    - No accept -> IDLE.
  - ERR1: HREADYOUT=0, HRESP=1 -> ERR2.
  - ERR2: HREADYOUT=1, HRESP=1; no memory access. Exit follows the IDLE accept rules.
- Writes: committed on the edge ending the DATA state.
  - Byte enables: size 0 -> lane HADDR[1:0]; size 1 -> lanes {HADDR[1],0} and {HADDR[1],1}; size 2 -> all four lanes.
  - Data is taken from the matching HWDATA lanes.
- Reads: HRDATA presents the full aligned word from a register loaded on the accept edge (WAIT_STATES=0) or on the last WAIT edge. The master selects lanes.
- Read-after-write hazard: if a read is accepted on the same edge that commits a write to the same word, HRDATA returns the merged (post-write) word.
- HRDATA holds its last value outside read data phases.
- Pipelining: back-to-back NONSEQ/SEQ with zero waits gives one transfer per cycle.

Optional Feature:
- Macro: RISCV_MEMORY_AHB4_RANGE_CHECK_EN.
- Defined: address outside [BASE_ADDR, BASE_ADDR+MEM_SIZE-1] is an error transfer (ERR1/ERR2, no write).
- Undefined: no range check; word index = (HADDR-BASE_ADDR)[log2(MEM_SIZE)-1:2], so accesses wrap modulo MEM_SIZE.

Test Plan:
1. WAIT_STATES=0: NONSEQ word write 'hDEADBEEF to 'h8000_0010, then NONSEQ read of the same address -> read data phase has HREADYOUT=1 and HRDATA='hDEADBEEF with zero waits (exercises the same-edge forwarding).
2. Byte write 'hAA to 'h8000_0013 over the word 'h11223344 -> subsequent read returns 'hAA223344. Halfword write 'h5566 to 'h8000_0010 -> read returns 'hAA225566.
3. WAIT_STATES=3: word read -> HREADYOUT low for exactly 3 cycles, then high with data. The master holds the next address phase during the wait cycles; it is accepted only on the completing edge.
4. Halfword write to 'h8000_0001 -> ERR1 (HREADYOUT=0, HRESP=1) then ERR2 (HREADYOUT=1, HRESP=1); memory word unchanged.
5. Address 'h8000_1000 with MEM_SIZE=4096 -> ERROR response if the macro is defined; otherwise aliases to location 0 (read returns the word at 'h8000_0000).
6. Assert HRESETn during the WAIT state of a write -> HREADYOUT=1, HRESP=0, HRDATA=0 immediately; target word unchanged.
